// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signed or unsigned
// operands, valid/ready on both sides and a synchronous flush.
module iter_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] div_src1,
   input  logic [WIDTH-1:0] div_src2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    count;
   logic             q_neg;
   logic             r_neg;

   logic             accept;
   logic [WIDTH-1:0] abs1;
   logic [WIDTH-1:0] abs2;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] r_step;

   assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN);

   assign abs1 = (op_signed && div_src1[WIDTH-1]) ? -div_src1 : div_src1;
   assign abs2 = (op_signed && div_src2[WIDTH-1]) ? -div_src2 : div_src2;

   // The partial remainder is always below the divisor, so the top bit of the
   // WIDTH+1 bit difference is a clean borrow: set means "does not fit".
   assign rem_sh = {rem, dvd[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs};
   assign r_step = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign q_step = {dvd[WIDTH-2:0], ~diff[WIDTH]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         count     <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else if (accept) begin
         if (div_src2 == '0) begin
            quotient  <= '1;
            remainder <= div_src1;
            state     <= DONE;
         end else begin
            dvd   <= abs1;
            dvs   <= abs2;
            q_neg <= op_signed && (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
            r_neg <= op_signed && div_src1[WIDTH-1];
            rem   <= '0;
            count <= '0;
            state <= RUN;
         end
      end else begin
         case (state)
            RUN: begin
               // The dividend register doubles as the quotient shift register.
               dvd   <= q_step;
               rem   <= r_step;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  quotient  <= q_neg ? -q_step : q_step;
                  remainder <= r_neg ? -r_step : r_step;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule
